irq_ctrl: RTL
=============

# irq_ctrl

Interrupt controller for the mips789 core: the requester side of the `irq`/`iack` handshake consumed by the pipeline control FSM. It captures rising edges on up to `N_SRC` external interrupt lines, masks and prioritises them, raises `irq` to the core and holds the winning cause until the core acknowledges. When the core returns from the handler, the pending bit is cleared automatically. Software access to pending, mask, cause and enable is through a small register port driven by the load/store path.

## Interface
- `N_SRC`, 8 — number of interrupt source lines (1..32)
- `W_IDX`, 3 — width of the cause index; must equal clog2(`N_SRC`), minimum 1
- `clk`  in  1  — single clock; everything is synchronous to its rising edge
- `rst`  in  1  — synchronous, active-high reset
- `irq_src`  in  `N_SRC`  — raw interrupt lines; rising-edge sensitive
- `iack`  in  1  — acknowledge from the pipeline FSM; high from IRQ entry until RET
- `irq`  out  1  — interrupt request to the pipeline FSM; registered
- `cause_idx`  out  `W_IDX`  — index of the request in flight or in service; registered
- `reg_wr`  in  1  — register write strobe, one cycle
- `reg_addr`  in  2  — register select
- `reg_wdata`  in  32  — write data
- `reg_rdata`  out  32  — read data, registered, valid one cycle after `reg_addr`

## Operation
- **Register map**
  - Address 0, PEND: read-only view of pending bits; writing 1 to a bit clears it (W1C).
  - Address 1, MASK: read/write; 1 enables that source.
  - Address 2, CAUSE: bit31 = in-service; bits[`W_IDX`-1:0] = `cause_idx`.
  - Address 3, CTRL: bit0 = global enable.
  - Unused bits read 0.
- **Edge capture:** `irq_src` is registered every cycle. A bit sampled 1 whose previous sample was 0 sets `pend[i]`.
- **Set/clear priority:** a set always beats a clear in the same cycle, whether the clear is a W1C write or the DONE auto-clear.
- **Eligible:** `pend & mask`, gated by CTRL.en. The winner is the lowest set index.
- **FSM** (states IDLE, REQ, SERV, DONE):
  - **IDLE:** if eligible ≠ 0 and `iack`=0, latch the winner into `cause_idx` and go to REQ. A stray `iack`=1 in IDLE is ignored, and no request starts until `iack` is 0.
  - **REQ:** `irq`=1. `cause_idx` is frozen and the request is never withdrawn: MASK, CTRL or W1C writes do not drop `irq`. On `iack`=1, go to SERV.
  - **SERV:** `irq`=0, CAUSE.bit31=1. On `iack`=0, go to DONE.
  - **DONE:** clear `pend[cause_idx]` (subject to the set-wins rule), then go to IDLE. This gives `irq` at least 2 low cycles between services.
- **Reset values:** `irq`=0, `cause_idx`=0, `reg_rdata`=0, PEND=0, MASK=0, CTRL=0, edge-sample register=0, state IDLE. A reset asserted mid-service returns to IDLE with all pending lost.

## Timing
- **Request latency:** source sampled low at edge k-1 and high at edge k gives PEND set after edge k. `irq` rises after edge k+1 (2 cycles), provided the source is enabled and the FSM is in IDLE.
- **Into service:** `iack` sampled high at edge m drops `irq` after edge m.
- **Release:** `iack` sampled low at edge n moves the FSM to DONE after edge n. The pending bit clears and the FSM is in IDLE after edge n+1. The earliest next `irq` is after edge n+2.
- **Register writes** take effect at the edge where `reg_wr` is sampled. A read issued in the same cycle returns the pre-write value.
- **Source width:** a source held high continuously produces exactly one pending set. Sources need to be high for only one sampled edge.

## Structure
- **Shared package `irq_ctrl_pkg`:** register address constants (`IRQ_PEND`, `IRQ_MASK`, `IRQ_CAUSE`, `IRQ_CTRL`) and the FSM state encoding. Add these alongside the existing FSM/PC defines in `mips789_defs.v`.
- **Sub-module `irq_prio_enc`:** combinational lowest-index-first priority encoder, `N_SRC` → `W_IDX` plus a `valid` output.

## Test plan
- **Basic handshake:** reset; MASK=0xFF, CTRL=1; pulse `irq_src[5]` for 1 cycle. Required: `irq`=1 two cycles later with `cause_idx`=5. Raise `iack`: `irq` drops next cycle and CAUSE reads 0x8000_0005. Drop `iack`: PEND reads 0 two cycles later.
- **Priority:** sources 6 and 2 rise together. Required: cause 2 is serviced first. After DONE and IDLE, `irq` rises again with cause 6.
- **Masking:** MASK=0x00, pulse source 3. Required: PEND=0x08 and `irq` stays 0. Then MASK=0x08: `irq`=1 one cycle after the write.
- **Simultaneous set/clear:** W1C of bit 4 in the same cycle as a new source-4 edge. Required: PEND bit 4 remains 1. The same holds for a new source-4 edge during DONE of cause 4.
- **No withdrawal:** in REQ, write MASK=0 and W1C all bits. Required: `irq` stays 1 and `cause_idx` is unchanged until `iack`.
- **Reset mid-service:** assert `rst` in SERV for 1 cycle. Required: `irq`=0, PEND=0, MASK=0, CAUSE=0 on the next cycle. `iack` still high afterwards must not start a request.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register addresses and FSM state encoding shared by the interrupt controller
package irq_ctrl_pkg;
  localparam logic [1:0] IRQ_PEND  = 2'd0;
  localparam logic [1:0] IRQ_MASK  = 2'd1;
  localparam logic [1:0] IRQ_CAUSE = 2'd2;
  localparam logic [1:0] IRQ_CTRL  = 2'd3;
  typedef enum logic [1:0] {IDLE, REQ, SERV, DONE} irq_state_e;
endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: irq_src/iack/irq/cause_idx handshake plus reg_wr/reg_addr/reg_wdata/reg_rdata port; slave = controller, master = core/bus side
interface irq_ctrl_if #(parameter int N_SRC = 8, parameter int W_IDX = 3);
  logic [N_SRC-1:0] irq_src;
  logic iack;
  logic irq;
  logic [W_IDX-1:0] cause_idx;
  logic reg_wr;
  logic [1:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  modport master(output irq_src, iack, reg_wr, reg_addr, reg_wdata, input irq, cause_idx, reg_rdata);
  modport slave(input irq_src, iack, reg_wr, reg_addr, reg_wdata, output irq, cause_idx, reg_rdata);
endinterface

// File: rtl/irq_ctrl_prio_enc.sv
// irq_prio_enc: lowest-index-first priority encoder, req[N_SRC] -> idx[W_IDX] plus valid
module irq_prio_enc #(parameter int N_SRC = 8, parameter int W_IDX = 3) (
  input  logic [N_SRC-1:0] req,
  output logic [W_IDX-1:0] idx,
  output logic             valid
);
  always_comb begin
    idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) if (req[i]) idx = W_IDX'(i);
  end
  assign valid = |req;
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-capturing masked priority interrupt requester; ports clk, rst, bus (irq_ctrl_if.slave: irq_src/iack/irq/cause_idx + reg port)
module irq_ctrl import irq_ctrl_pkg::*; #(parameter int N_SRC = 8, parameter int W_IDX = 3) (
  input logic       clk,
  input logic       rst,
  irq_ctrl_if.slave bus
);
  irq_state_e state, state_n;
  logic [N_SRC-1:0] src_q, pend, mask, elig, clr;
  logic en, win_v, start;
  logic [W_IDX-1:0] win;
  logic [31:0] cause_w, rdata_n;
  always_comb elig = en ? pend & mask : '0;
  irq_prio_enc #(.N_SRC(N_SRC), .W_IDX(W_IDX)) u_enc (.req(elig), .idx(win), .valid(win_v));
  always_comb begin
    state_n = state;
    start = 1'b0;
    case (state)
      IDLE: if (win_v && !bus.iack) begin
        state_n = REQ;
        start = 1'b1;
      end
      REQ: if (bus.iack) state_n = SERV;
      SERV: if (!bus.iack) state_n = DONE;
      default: state_n = IDLE;
    endcase
    clr = (bus.reg_wr && bus.reg_addr == IRQ_PEND) ? bus.reg_wdata[N_SRC-1:0] : '0;
    if (state == DONE) clr[bus.cause_idx] = 1'b1;
  end
  always_comb begin
    cause_w = 32'(bus.cause_idx);
    cause_w[31] = state == SERV;
    rdata_n = bus.reg_addr == IRQ_PEND ? 32'(pend) :
              bus.reg_addr == IRQ_MASK ? 32'(mask) :
              bus.reg_addr == IRQ_CAUSE ? cause_w : {31'b0, en};
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= '0;
      pend <= '0;
      mask <= '0;
      en <= 1'b0;
      bus.irq <= 1'b0;
      bus.cause_idx <= '0;
      bus.reg_rdata <= '0;
    end else begin
      src_q <= bus.irq_src;
      pend <= (pend & ~clr) | (bus.irq_src & ~src_q);
      if (bus.reg_wr && bus.reg_addr == IRQ_MASK) mask <= bus.reg_wdata[N_SRC-1:0];
      if (bus.reg_wr && bus.reg_addr == IRQ_CTRL) en <= bus.reg_wdata[0];
      bus.irq <= state_n == REQ;
      if (start) bus.cause_idx <= win;
      bus.reg_rdata <= rdata_n;
    end
  end
endmodule
